axi_rd_responder: RTL and testbench

AXI4 read-channel responder (slave end) backed by an on-chip word memory; it answers AR requests with R bursts. It sits at the downstream end of a read path, after interconnect or width-adapter logic, as the target model and functional endpoint for master-side read traffic. A sideband load port fills the memory without using AXI.

---
 rtl/axi_pkg.sv | 14 +
 rtl/axi_burst_addr_gen.sv | 34 +++
 rtl/axi_rd_responder.sv | 139 +++++++++++++
 tb/tb_axi_rd_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the read-responder state type.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address and burst-legality calculation.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_LSB   = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  err
);
    logic [8:0]            w_beats;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_mask;
    logic [ADDR_WIDTH-1:0] w_inc;

    always_comb begin
        w_beats = {1'b0, len} + 9'd1;
        w_step  = ADDR_WIDTH'(1) << size;
        w_mask  = (ADDR_WIDTH'(w_beats) << size) - ADDR_WIDTH'(1);
        w_inc   = addr + w_step;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = w_inc;
            BURST_WRAP:  next_addr = (addr & ~w_mask) | (w_inc & w_mask);
            default:     next_addr = w_inc;
        endcase
        err = (burst == 2'd3) || (int'(size) > WORD_LSB) ||
              ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    end
endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder backed by an on-chip word memory with a sideband load port.
// state    | meaning
// ST_IDLE  | accepting AR (once out of reset)
// ST_BURST | fetching words and returning R beats until the rlast handshake
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int WORD_LSB   = $clog2(DATA_WIDTH/8)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_WIDTH-1:0]      s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic [7:0]               s_axi_arlen,
    input  logic [2:0]               s_axi_arsize,
    input  logic [1:0]               s_axi_arburst,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [ID_WIDTH-1:0]      s_axi_rid,
    output logic [DATA_WIDTH-1:0]    s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rlast,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    input  logic                     ld_en,
    input  logic [ADDR_WIDTH-WORD_LSB-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data
);
    localparam int DEPTH = 2**(ADDR_WIDTH-WORD_LSB);

    rd_state_e r_state, w_next_state;
    logic                  r_up;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [8:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_q;
    logic                  r_q_vld, r_q_last, r_q_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rvalid, r_rlast;
    logic [1:0]            r_rresp;

    logic                  w_ar_hs, w_r_hs, w_out_free, w_s1_free, w_issue, w_err;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [ADDR_WIDTH-WORD_LSB-1:0] w_idx;

    axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .WORD_LSB(WORD_LSB)) u_addr_gen (
        .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst),
        .next_addr(w_next_addr), .err(w_err)
    );

    // Two stages: memory read register, then R output register; each stalls only when full.
    assign w_ar_hs    = s_axi_arvalid && s_axi_arready;
    assign w_r_hs     = r_rvalid && s_axi_rready;
    assign w_out_free = !r_rvalid || s_axi_rready;
    assign w_s1_free  = !r_q_vld || w_out_free;
    assign w_idx      = r_addr[ADDR_WIDTH-1:WORD_LSB];
    assign w_issue    = (r_state == ST_BURST) && (r_cnt != ({1'b0, r_len} + 9'd1)) && w_s1_free;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_hs) w_next_state = ST_BURST;
            ST_BURST: if (w_r_hs && r_rlast) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = (r_state == ST_IDLE) && r_up;
    end

    always_ff @(posedge clk) begin
        if (ld_en) r_mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_up     <= 1'b0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_mem_q  <= '0;
            r_q_vld  <= 1'b0;
            r_q_last <= 1'b0;
            r_q_err  <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rresp  <= RESP_OKAY;
        end else begin
            r_up <= 1'b1;
            if (w_ar_hs) begin
                r_id    <= s_axi_arid;
                r_addr  <= s_axi_araddr;
                r_len   <= s_axi_arlen;
                r_size  <= s_axi_arsize;
                r_burst <= s_axi_arburst;
                r_cnt   <= '0;
            end
            if (w_issue) begin
                r_mem_q  <= w_err ? '0 : r_mem[w_idx];
                r_q_vld  <= 1'b1;
                r_q_last <= (r_cnt == {1'b0, r_len});
                r_q_err  <= w_err;
                r_addr   <= w_next_addr;
                r_cnt    <= r_cnt + 9'd1;
            end else if (w_out_free) begin
                r_q_vld <= 1'b0;
            end
            if (w_out_free) begin
                r_rvalid <= r_q_vld;
                r_rdata  <= r_mem_q;
                r_rlast  <= r_q_vld && r_q_last;
                r_rresp  <= r_q_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s_axi_rid    = r_id;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign s_axi_rlast  = r_rlast;
    assign s_axi_rvalid = r_rvalid;
endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed self-checking bench for axi_rd_responder.
module tb_axi_rd_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  arid = '0;
    logic [15:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic        rready = 1'b1;
    logic        ld_en = 1'b0;
    logic [13:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] g_data [0:15];
    logic [1:0]  g_resp [0:15];
    logic        g_last [0:15];
    logic [7:0]  g_id   [0:15];
    int g_n, g_first, g_stall_err, g_ar_hi;

    always #5 clk = ~clk;

    axi_rd_responder dut (
        .clk(clk), .rst(rst),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = 14'(a); ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        ok = arready;
        tick();
        arvalid = 1'b0;
    endtask

    // Cycle c counts points since the AR handshake edge; ld_at injects one load at that point.
    task automatic collect(input int n, input bit toggle, input int ld_at, input int ld_a,
                           input logic [31:0] ld_d);
        bit pat [0:3];
        logic [31:0] held;
        bit stalled;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        held = '0; stalled = 1'b0;
        g_n = 0; g_first = -1; g_stall_err = 0; g_ar_hi = 0;
        for (int c = 0; c < 300 && g_n < n; c++) begin
            rready = toggle ? pat[c % 4] : 1'b1;
            ld_en = (c == ld_at);
            if (c == ld_at) begin ld_addr = 14'(ld_a); ld_data = ld_d; end
            if (arready) g_ar_hi++;
            if (stalled && (!rvalid || rdata !== held)) g_stall_err++;
            stalled = 1'b0;
            if (rvalid && g_first < 0) g_first = c;
            if (rvalid) begin
                if (rready) begin
                    if (g_n < 16) begin
                        g_data[g_n] = rdata; g_resp[g_n] = rresp;
                        g_last[g_n] = rlast; g_id[g_n] = rid;
                    end
                    g_n++;
                end else begin
                    stalled = 1'b1; held = rdata;
                end
            end
            tick();
        end
        ld_en = 1'b0;
        rready = 1'b1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        tick(); tick();
        total++; if (arready !== 1'b0) begin bad++; $display("FAIL reset_arready got %b want 0", arready); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
        total++; if (rlast !== 1'b0) begin bad++; $display("FAIL reset_rlast got %b want 0", rlast); end
        total++; if (rid !== 8'h00) begin bad++; $display("FAIL reset_rid got %h want 00", rid); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
        total++; if (rresp !== 2'd0) begin bad++; $display("FAIL reset_rresp got %0d want 0", rresp); end
        rst = 1'b1;
        total++; if (arready !== 1'b0) begin bad++; $display("FAIL release_arready_early got %b want 0", arready); end
        tick();
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL release_arready got %b want 1", arready); end
        for (int i = 0; i < 32; i++) load_word(i, 32'h1000_0000 + i);
    endtask

    task automatic test_incr;
        bit ok;
        send_ar(8'h5A, 16'h0010, 8'd3, 3'd2, 2'd1, ok);
        collect(4, 1'b0, -1, 0, '0);
        total++; if (!ok) begin bad++; $display("FAIL incr_ar_accept got 0 want 1"); end
        total++; if (g_n !== 4) begin bad++; $display("FAIL incr_beats got %0d want 4", g_n); end
        total++; if (g_first !== 2) begin bad++; $display("FAIL incr_latency got %0d want 2", g_first); end
        for (int i = 0; i < 4; i++) begin
            total++; if (g_data[i] !== 32'h1000_0004 + i) begin bad++; $display("FAIL incr_data beat %0d got %h want %h", i, g_data[i], 32'h1000_0004 + i); end
            total++; if (g_last[i] !== (i == 3)) begin bad++; $display("FAIL incr_rlast beat %0d got %b want %b", i, g_last[i], i == 3); end
            total++; if (g_resp[i] !== 2'd0) begin bad++; $display("FAIL incr_rresp beat %0d got %0d want 0", i, g_resp[i]); end
            total++; if (g_id[i] !== 8'h5A) begin bad++; $display("FAIL incr_rid beat %0d got %h want 5a", i, g_id[i]); end
        end
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL incr_turnaround got %b want 1", arready); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL incr_extra_beat got %b want 0", rvalid); end
    endtask

    task automatic test_wrap_fixed;
        bit ok;
        logic [31:0] exp_w [0:3];
        exp_w = '{32'h1000_000E, 32'h1000_000F, 32'h1000_000C, 32'h1000_000D};
        send_ar(8'h21, 16'h0038, 8'd3, 3'd2, 2'd2, ok);
        collect(4, 1'b0, -1, 0, '0);
        total++; if (g_n !== 4) begin bad++; $display("FAIL wrap_beats got %0d want 4", g_n); end
        for (int i = 0; i < 4; i++) begin
            total++; if (g_data[i] !== exp_w[i]) begin bad++; $display("FAIL wrap_data beat %0d got %h want %h", i, g_data[i], exp_w[i]); end
        end
        total++; if (g_last[3] !== 1'b1 || g_resp[3] !== 2'd0) begin bad++; $display("FAIL wrap_last got last=%b resp=%0d want 1/0", g_last[3], g_resp[3]); end
        send_ar(8'h22, 16'h0008, 8'd2, 3'd2, 2'd0, ok);
        collect(3, 1'b0, -1, 0, '0);
        total++; if (g_n !== 3) begin bad++; $display("FAIL fixed_beats got %0d want 3", g_n); end
        for (int i = 0; i < 3; i++) begin
            total++; if (g_data[i] !== 32'h1000_0002) begin bad++; $display("FAIL fixed_data beat %0d got %h want 10000002", i, g_data[i]); end
            total++; if (g_last[i] !== (i == 2)) begin bad++; $display("FAIL fixed_rlast beat %0d got %b want %b", i, g_last[i], i == 2); end
        end
    endtask

    task automatic test_stall;
        bit ok;
        send_ar(8'h33, 16'h0000, 8'd7, 3'd2, 2'd1, ok);
        collect(8, 1'b1, -1, 0, '0);
        total++; if (g_n !== 8) begin bad++; $display("FAIL stall_beats got %0d want 8", g_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (g_data[i] !== 32'h1000_0000 + i) begin bad++; $display("FAIL stall_data beat %0d got %h want %h", i, g_data[i], 32'h1000_0000 + i); end
        end
        total++; if (g_last[7] !== 1'b1 || g_last[6] !== 1'b0) begin bad++; $display("FAIL stall_rlast got %b%b want 10", g_last[7], g_last[6]); end
        total++; if (g_stall_err !== 0) begin bad++; $display("FAIL stall_hold got %0d changes want 0", g_stall_err); end
        total++; if (g_ar_hi !== 0) begin bad++; $display("FAIL stall_arready_in_burst got %0d cycles want 0", g_ar_hi); end
        total++; if (arready !== 1'b1 || rvalid !== 1'b0) begin bad++; $display("FAIL stall_turnaround got ar=%b rv=%b want 1/0", arready, rvalid); end
    endtask

    task automatic test_errors;
        logic [1:0] t_burst [0:2];
        logic [2:0] t_size  [0:2];
        logic [7:0] t_len   [0:2];
        bit ok;
        int n;
        t_burst = '{2'd3, 2'd1, 2'd2};
        t_size  = '{3'd2, 3'd3, 3'd2};
        t_len   = '{8'd3, 8'd3, 8'd2};
        for (int k = 0; k < 3; k++) begin
            n = int'(t_len[k]) + 1;
            send_ar(8'h40 + 8'(k), 16'h0010, t_len[k], t_size[k], t_burst[k], ok);
            collect(n, 1'b0, -1, 0, '0);
            total++; if (g_n !== n) begin bad++; $display("FAIL err%0d_beats got %0d want %0d", k, g_n, n); end
            for (int i = 0; i < n; i++) begin
                total++; if (g_resp[i] !== 2'd2) begin bad++; $display("FAIL err%0d_rresp beat %0d got %0d want 2", k, i, g_resp[i]); end
                total++; if (g_data[i] !== 32'h0) begin bad++; $display("FAIL err%0d_rdata beat %0d got %h want 0", k, i, g_data[i]); end
                total++; if (g_last[i] !== (i == n - 1)) begin bad++; $display("FAIL err%0d_rlast beat %0d got %b want %b", k, i, g_last[i], i == n - 1); end
            end
        end
    endtask

    task automatic test_load_collision;
        bit ok;
        send_ar(8'h50, 16'h0040, 8'd3, 3'd2, 2'd1, ok);
        collect(4, 1'b0, 1, 17, 32'hDEAD_0017);
        total++; if (g_data[1] !== 32'h1000_0011) begin bad++; $display("FAIL collide_old_data got %h want 10000011", g_data[1]); end
        total++; if (g_data[2] !== 32'h1000_0012) begin bad++; $display("FAIL collide_next_data got %h want 10000012", g_data[2]); end
        send_ar(8'h51, 16'h0044, 8'd0, 3'd2, 2'd1, ok);
        collect(1, 1'b0, -1, 0, '0);
        total++; if (g_data[0] !== 32'hDEAD_0017 || g_last[0] !== 1'b1) begin bad++; $display("FAIL collide_new_data got %h last=%b want dead0017/1", g_data[0], g_last[0]); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        send_ar(8'h60, 16'h0000, 8'd7, 3'd2, 2'd1, ok);
        rready = 1'b1;
        tick(); tick(); tick(); tick();
        total++; if (rvalid !== 1'b1 || rdata !== 32'h1000_0002) begin bad++; $display("FAIL midrst_beat2 got rv=%b %h want 1/10000002", rvalid, rdata); end
        rst = 1'b0;
        #1;
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got %b want 0", rvalid); end
        tick();
        rst = 1'b1;
        total++; if (arready !== 1'b0) begin bad++; $display("FAIL midrst_arready_early got %b want 0", arready); end
        tick();
        total++; if (arready !== 1'b1) begin bad++; $display("FAIL midrst_arready got %b want 1", arready); end
        send_ar(8'h61, 16'h0010, 8'd3, 3'd2, 2'd1, ok);
        collect(4, 1'b0, -1, 0, '0);
        total++; if (!ok || g_n !== 4 || g_first !== 2) begin bad++; $display("FAIL midrst_next_burst got ok=%b n=%0d lat=%0d want 1/4/2", ok, g_n, g_first); end
        total++; if (g_data[0] !== 32'h1000_0004 || g_data[3] !== 32'h1000_0007 || g_id[3] !== 8'h61) begin bad++; $display("FAIL midrst_next_data got %h %h id=%h want 10000004 10000007 61", g_data[0], g_data[3], g_id[3]); end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_stall();
        test_errors();
        test_load_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
